// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial transceiver (transmitter and receiver).
//   DATA_BITS      : payload bits per frame
//   serial_state_t : frame state encoding used by the receiver FSM
// -----------------------------------------------------------------------------
package serial_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } serial_state_t;

endpackage : serial_pkg

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input.
//   clk  in  : destination clock
//   rst  in  : asynchronous active-high reset; both flops load RESET_VAL
//   d    in  : asynchronous input
//   q    out : synchronized output, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flops are written with non-blocking assignments so every register
    // samples the pre-edge value; blocking here would collapse the two stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync2

// File: rtl/receiver.sv
// -----------------------------------------------------------------------------
// receiver
// Serial frame receiver: 1 start bit (low), DATA_BITS data bits LSB first,
// 1 stop bit (high), idle high. Oversamples din at CLK_DIV clocks per bit and
// samples each bit at mid-period.
//   clk       in      : system clock, rising edge
//   rst       in      : asynchronous active-high reset
//   din       in      : serial line, asynchronous, idle high
//   rx_data   out [8] : last correctly framed byte, held until next good frame
//   rx_valid  out     : one-cycle pulse when rx_data updates
//   rx_err    out     : one-cycle pulse when the stop bit is sampled low
//   rx_status out     : 1 = idle/ready, 0 = frame in progress (or line break)
// -----------------------------------------------------------------------------
module receiver
    import serial_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_err,
    output logic                 rx_status
);

    localparam int H     = CLK_DIV / 2;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(DATA_BITS);

    logic                 din_s;
    serial_state_t        state,    state_next;
    logic [CNT_W-1:0]     cnt,      cnt_next;
    logic [IDX_W-1:0]     bit_idx,  bit_idx_next;
    logic [DATA_BITS-1:0] shift,    shift_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 valid_next;
    logic                 err_next;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (din_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
            rx_data  <= data_next;
            rx_valid <= valid_next;
            rx_err   <= err_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        data_next    = rx_data;
        valid_next   = 1'b0;
        err_next     = 1'b0;

        unique case (state)
            IDLE: begin
                if (!din_s) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a high here was a glitch.
                if (cnt == CNT_W'(H - 1)) begin
                    if (din_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next   = DATA;
                        cnt_next     = '0;
                        bit_idx_next = '0;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                // Counting from mid start bit, a full period lands mid data bit.
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    shift_next   = {din_s, shift[DATA_BITS-1:1]};
                    cnt_next     = '0;
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_next = '0;
                    if (din_s) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a stuck-low line is
                // not decoded as an endless run of 0x00 frames.
                if (din_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rx_status = (state == IDLE);

endmodule : receiver
